// File: rtl/if_fetch_req_ctrl_if.sv
// SRAM-like instruction bus between the fetch request controller (master)
// and the instruction memory (slave): req/addr_ok/data_ok handshake.
interface if_fetch_req_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [3:0]        inst_wstrb;
  logic [DATA_W-1:0] inst_wdata;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/if_fetch_req_ctrl.sv
// IF-stage fetch request controller: one outstanding instruction read, a
// single-entry return buffer toward decode, stale-response discard on flush.
module if_fetch_req_ctrl #(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [1:0] INST_SIZE = 2'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fs_pc_valid,
  input  logic [ADDR_W-1:0] fs_pc,
  output logic              fs_pc_ready,
  input  logic              flush,
  input  logic              ds_allow_in,
  output logic              fs_inst_valid,
  output logic [DATA_W-1:0] fs_inst,
  output logic [ADDR_W-1:0] fs_inst_pc,
  output logic              fs_inst_ex,
  if_fetch_req_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              buf_valid;
  logic [DATA_W-1:0] buf_inst;
  logic [ADDR_W-1:0] buf_pc;
  logic              buf_ex;
  logic              discard;
  logic [ADDR_W-1:0] req_pc;

  logic accept;
  logic misaligned;
  logic data_take;

  // Reset gates ready so nothing looks accepted while the block is held in reset.
  always_comb begin
    fs_pc_ready = 1'b0;
    accept      = 1'b0;
    misaligned  = 1'b0;
    data_take   = 1'b0;
    fs_pc_ready = !reset && (state == S_IDLE) && !flush && (!buf_valid || ds_allow_in);
    accept      = fs_pc_valid && fs_pc_ready;
    misaligned  = accept && (fs_pc[1:0] != 2'b00);
    data_take   = (state == S_WAIT) && bus.inst_data_ok && !discard && !flush;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !misaligned) state_nxt = S_REQ;
      S_REQ:   if (bus.inst_addr_ok)      state_nxt = S_WAIT;
      S_WAIT:  if (bus.inst_data_ok)      state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      req_pc <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= fs_pc;
    end
  end

  // A request already on the bus cannot be withdrawn, so a flush only marks
  // its eventual response for dropping; data_ok in the flush cycle drops it directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      discard <= 1'b0;
    end else if (state == S_REQ) begin
      if (flush) discard <= 1'b1;
    end else if (state == S_WAIT) begin
      if (bus.inst_data_ok) discard <= 1'b0;
      else if (flush)       discard <= 1'b1;
    end
  end

  // Return buffer: flush wins, then a fill (bus data or ADEF), then drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_inst  <= '0;
      buf_pc    <= '0;
      buf_ex    <= 1'b0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (data_take) begin
      buf_valid <= 1'b1;
      buf_inst  <= bus.inst_rdata;
      buf_pc    <= req_pc;
      buf_ex    <= 1'b0;
    end else if (misaligned) begin
      buf_valid <= 1'b1;
      buf_inst  <= '0;
      buf_pc    <= fs_pc;
      buf_ex    <= 1'b1;
    end else if (buf_valid && ds_allow_in) begin
      buf_valid <= 1'b0;
    end
  end

  assign fs_inst_valid  = buf_valid;
  assign fs_inst        = buf_inst;
  assign fs_inst_pc     = buf_pc;
  assign fs_inst_ex     = buf_ex;

  assign bus.inst_req   = (state == S_REQ);
  assign bus.inst_addr  = req_pc;
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = INST_SIZE;
  assign bus.inst_wstrb = 4'b0000;
  assign bus.inst_wdata = '0;

endmodule

// File: tb/tb_if_fetch_req_ctrl.sv
// Directed testbench for if_fetch_req_ctrl: stimulus pushes expected
// decode-side entries into a queue, a negedge monitor pops and compares them.
module tb_if_fetch_req_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              ex;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              fs_pc_valid;
  logic [ADDR_W-1:0] fs_pc;
  logic              fs_pc_ready;
  logic              flush;
  logic              ds_allow_in;
  logic              fs_inst_valid;
  logic [DATA_W-1:0] fs_inst;
  logic [ADDR_W-1:0] fs_inst_pc;
  logic              fs_inst_ex;

  if_fetch_req_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  if_fetch_req_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INST_SIZE(2'd2)) dut (
    .clk          (clk),
    .reset        (reset),
    .fs_pc_valid  (fs_pc_valid),
    .fs_pc        (fs_pc),
    .fs_pc_ready  (fs_pc_ready),
    .flush        (flush),
    .ds_allow_in  (ds_allow_in),
    .fs_inst_valid(fs_inst_valid),
    .fs_inst      (fs_inst),
    .fs_inst_pc   (fs_inst_pc),
    .fs_inst_ex   (fs_inst_ex),
    .bus          (bus.master)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: every entry decode takes must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && fs_inst_valid && ds_allow_in) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_entry: got inst=0x%08h pc=0x%08h ex=%0b, expected no entry",
                 fs_inst, fs_inst_pc, fs_inst_ex);
      end else begin
        e = sb.pop_front();
        if (fs_inst !== e.inst || fs_inst_pc !== e.pc || fs_inst_ex !== e.ex) begin
          errors++;
          $display("[TB] FAIL entry: got inst=0x%08h pc=0x%08h ex=%0b, expected inst=0x%08h pc=0x%08h ex=%0b",
                   fs_inst, fs_inst_pc, fs_inst_ex, e.inst, e.pc, e.ex);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_inst_req"},   32'(bus.inst_req),   32'd0);
    checkOutput({tag, "_inst_addr"},  bus.inst_addr,       32'd0);
    checkOutput({tag, "_inst_valid"}, 32'(fs_inst_valid),  32'd0);
    checkOutput({tag, "_inst"},       fs_inst,             32'd0);
    checkOutput({tag, "_inst_pc"},    fs_inst_pc,          32'd0);
    checkOutput({tag, "_inst_ex"},    32'(fs_inst_ex),     32'd0);
    checkOutput({tag, "_pc_ready"},   32'(fs_pc_ready),    32'd0);
  endtask

  // Full aligned fetch: accept, addr_ok in the req cycle, data_ok next cycle.
  // Returns at the start of the cycle in which the buffer should be valid.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] rdata);
    fs_pc_valid = 1'b1;
    fs_pc       = pc;
    sb.push_back('{inst: rdata, pc: pc, ex: 1'b0});
    @(negedge clk);
    checkOutput("accept_ready", 32'(fs_pc_ready), 32'd1);
    cyc();
    fs_pc_valid       = 1'b0;
    bus.inst_addr_ok  = 1'b1;
    @(negedge clk);
    checkOutput("req_high", 32'(bus.inst_req), 32'd1);
    checkOutput("req_addr", bus.inst_addr, pc);
    cyc();
    bus.inst_addr_ok  = 1'b0;
    bus.inst_data_ok  = 1'b1;
    bus.inst_rdata    = rdata;
    @(negedge clk);
    checkOutput("wait_req_low", 32'(bus.inst_req), 32'd0);
    cyc();
    bus.inst_data_ok  = 1'b0;
    bus.inst_rdata    = '0;
  endtask

  initial begin
    reset            = 1'b1;
    fs_pc_valid      = 1'b1;
    fs_pc            = 32'h1C00_0000;
    flush            = 1'b0;
    ds_allow_in      = 1'b1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    #2;
    checkAllZero("reset");
    checkOutput("const_size",  32'(bus.inst_size),  32'd2);
    checkOutput("const_wr",    32'(bus.inst_wr),    32'd0);
    checkOutput("const_wstrb", 32'(bus.inst_wstrb), 32'd0);
    checkOutput("const_wdata", bus.inst_wdata,      32'd0);
    fs_pc_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();

    $display("[TB] normal fetch");
    applyStimulus(32'h1C00_0000, 32'h0280_0C0C);
    @(negedge clk);
    checkOutput("normal_valid", 32'(fs_inst_valid), 32'd1);
    cyc();
    @(negedge clk);
    checkOutput("normal_valid_one_cycle", 32'(fs_inst_valid), 32'd0);
    cyc();

    $display("[TB] back-pressure");
    applyStimulus(32'h1C00_0004, 32'h1111_1111);
    ds_allow_in = 1'b0;
    fs_pc_valid = 1'b1;
    fs_pc       = 32'h1C00_0008;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_valid",   32'(fs_inst_valid), 32'd1);
      checkOutput("stall_inst",    fs_inst,            32'h1111_1111);
      checkOutput("stall_pc",      fs_inst_pc,         32'h1C00_0004);
      checkOutput("stall_ex",      32'(fs_inst_ex),    32'd0);
      checkOutput("stall_ready",   32'(fs_pc_ready),   32'd0);
      checkOutput("stall_req",     32'(bus.inst_req),  32'd0);
      cyc();
    end
    ds_allow_in = 1'b1;
    sb.push_back('{inst: 32'h2222_2222, pc: 32'h1C00_0008, ex: 1'b0});
    @(negedge clk);
    checkOutput("release_ready", 32'(fs_pc_ready), 32'd1);
    cyc();
    fs_pc_valid      = 1'b0;
    bus.inst_addr_ok = 1'b1;
    @(negedge clk);
    checkOutput("release_req",  32'(bus.inst_req), 32'd1);
    checkOutput("release_addr", bus.inst_addr,     32'h1C00_0008);
    checkOutput("release_drained", 32'(fs_inst_valid), 32'd0);
    cyc();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h2222_2222;
    cyc();
    bus.inst_data_ok = 1'b0;
    @(negedge clk);
    checkOutput("release_valid", 32'(fs_inst_valid), 32'd1);
    cyc();

    $display("[TB] misaligned pc");
    fs_pc_valid = 1'b1;
    fs_pc       = 32'h1C00_0002;
    sb.push_back('{inst: 32'h0, pc: 32'h1C00_0002, ex: 1'b1});
    @(negedge clk);
    checkOutput("adef_ready", 32'(fs_pc_ready), 32'd1);
    cyc();
    fs_pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("adef_no_req", 32'(bus.inst_req), 32'd0);
      if (i == 0) checkOutput("adef_valid", 32'(fs_inst_valid), 32'd1);
      cyc();
    end

    $display("[TB] flush in REQ with delayed addr_ok");
    fs_pc_valid = 1'b1;
    fs_pc       = 32'h1C00_0010;
    cyc();
    fs_pc_valid = 1'b0;
    flush       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.inst_addr_ok = 1'b1;
      @(negedge clk);
      checkOutput("flushreq_req",  32'(bus.inst_req), 32'd1);
      checkOutput("flushreq_addr", bus.inst_addr,     32'h1C00_0010);
      cyc();
      flush = 1'b0;
    end
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("flushreq_wait_req", 32'(bus.inst_req), 32'd0);
    cyc();
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    @(negedge clk);
    checkOutput("flushreq_dropped", 32'(fs_inst_valid), 32'd0);
    cyc();
    applyStimulus(32'h1C00_8000, 32'h0BAD_F00D);
    @(negedge clk);
    checkOutput("after_flushreq_valid", 32'(fs_inst_valid), 32'd1);
    cyc();

    $display("[TB] flush coincident with data_ok");
    fs_pc_valid = 1'b1;
    fs_pc       = 32'h1C00_0020;
    cyc();
    fs_pc_valid      = 1'b0;
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'h3333_3333;
    flush            = 1'b1;
    @(negedge clk);
    checkOutput("coinc_ready_blocked", 32'(fs_pc_ready), 32'd0);
    cyc();
    bus.inst_data_ok = 1'b0;
    flush            = 1'b0;
    @(negedge clk);
    checkOutput("coinc_dropped", 32'(fs_inst_valid), 32'd0);
    cyc();
    applyStimulus(32'h1C00_0024, 32'h4444_4444);
    @(negedge clk);
    checkOutput("coinc_next_valid", 32'(fs_inst_valid), 32'd1);
    cyc();

    $display("[TB] reset mid-WAIT");
    fs_pc_valid = 1'b1;
    fs_pc       = 32'h1C00_0030;
    cyc();
    fs_pc_valid      = 1'b0;
    bus.inst_addr_ok = 1'b1;
    cyc();
    bus.inst_addr_ok = 1'b0;
    reset            = 1'b1;
    fs_pc_valid      = 1'b1;
    #1;
    checkAllZero("midreset");
    cyc();
    fs_pc_valid = 1'b0;
    reset       = 1'b0;
    cyc();
    applyStimulus(32'h1C00_0040, 32'h5555_5555);
    @(negedge clk);
    checkOutput("post_reset_valid", 32'(fs_inst_valid), 32'd1);
    cyc();
    cyc();

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_req_ctrl.md
Name: if_fetch_req_ctrl

Overview:
- Sequences instruction fetches between the IF stage and an SRAM-like instruction bus (req/addr_ok/data_ok handshake).
- Holds one outstanding request and buffers the returned instruction until decode accepts it.
- Discards responses made stale by a flush (exception, ertn, branch cancel).
- Raises ADEF locally for misaligned PCs without issuing a bus request.

Parameters:
- ADDR_W, 32, PC and bus address width.
- DATA_W, 32, instruction width.
- INST_SIZE, 2'd2, value driven on inst_size (word access).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- fs_pc_valid  input  1  IF presents a PC to fetch.
- fs_pc  input  ADDR_W  PC to fetch.
- fs_pc_ready  output  1  controller accepts fs_pc this cycle.
- flush  input  1  pipeline redirect (wb_ex | ertn_flush | br_taken_cancel).
- ds_allow_in  input  1  decode accepts the buffered instruction.
- fs_inst_valid  output  1  buffered instruction/exception valid.
- fs_inst  output  DATA_W  buffered instruction word.
- fs_inst_pc  output  ADDR_W  PC of the buffered instruction.
- fs_inst_ex  output  1  ADEF flag for the buffered entry.
- inst_req  output  1  bus request.
- inst_wr  output  1  constant 0.
- inst_size  output  2  constant INST_SIZE.
- inst_addr  output  ADDR_W  request address.
- inst_wstrb  output  4  constant 0.
- inst_wdata  output  DATA_W  constant 0.
- inst_addr_ok  input  1  request accepted by the bus.
- inst_data_ok  input  1  read data returned.
- inst_rdata  input  DATA_W  read data.

Behaviour:
- Reset (async, immediate): state=IDLE, buf_valid=0, discard=0, req_pc=0. Outputs: inst_req=0, inst_addr=0, fs_inst_valid=0, fs_inst=0, fs_inst_pc=0, fs_inst_ex=0, fs_pc_ready=0 while reset is high.
- Buffer drain: when buf_valid && ds_allow_in, buf_valid clears next cycle.
- fs_pc_ready = (state==IDLE) && !flush && (!buf_valid || ds_allow_in).
- Accept = fs_pc_valid && fs_pc_ready. On accept, latch req_pc <= fs_pc.
  - If fs_pc[1:0] != 0: no bus request, state stays IDLE. Next cycle the buffer holds {ex=1, inst=0, pc=fs_pc} with buf_valid=1.
  - Otherwise: state goes to REQ.
- REQ: inst_req=1, inst_addr=req_pc; both are held stable until inst_addr_ok. On addr_ok, state goes to WAIT.
- WAIT: inst_req=0. On data_ok, state goes to IDLE.
  - If discard=0 and no flush in the same cycle: buffer <= {ex=0, inst_rdata, req_pc}, buf_valid=1.
  - Otherwise the data is dropped and discard clears.
- Latency: accept at cycle N, inst_req at N+1. With addr_ok at N+1 and data_ok at N+2, fs_inst_valid is high at N+3.
- Flush in any state clears buf_valid next cycle, and the accept in that cycle is blocked.
- Flush in REQ (addr_ok or not): the request cannot be withdrawn. Set discard=1 and keep inst_req/inst_addr unchanged until addr_ok, then go to WAIT; that response is dropped.
- Flush in WAIT: set discard=1, unless data_ok arrives in the same cycle, in which case the data is dropped directly and discard stays 0.
- Flush in IDLE: only clears the buffer. A PC presented in the following cycle is accepted normally.
- A repeated flush while discard=1 has no further effect; there is at most one response to drop.
- data_ok outside WAIT is a protocol violation; it is ignored.
- Buffer full and decode stalled: no new accept. The buffered entry stays stable (valid, inst, pc, ex) until taken or flushed.

Test Plan:
- Normal fetch: pc=0x1C000000, addr_ok same cycle as req, data_ok next cycle with rdata=0x02800C0C, ds_allow_in=1 -> fs_inst_valid for 1 cycle with inst=0x02800C0C, pc=0x1C000000, ex=0.
- Back-pressure: ds_allow_in=0 for 5 cycles after data return -> entry held stable, fs_pc_ready=0, no inst_req. Set ds_allow_in=1 -> entry consumed, next PC accepted in the same cycle.
- Misaligned PC: pc=0x1C000002 -> inst_req never asserted; next cycle fs_inst_valid=1, ex=1, pc=0x1C000002.
- Flush in REQ with addr_ok delayed 3 cycles: inst_req/inst_addr held stable throughout; after addr_ok, data_ok with rdata=0xDEADBEEF is dropped (fs_inst_valid stays 0); then fetch of 0x1C008000 completes normally.
- Flush coincident with data_ok in WAIT: data dropped, discard ends at 0. The following fetch delivers its first data_ok.
- Reset asserted mid-WAIT: all outputs 0 immediately, state=IDLE. After reset release, the first accepted PC issues a fresh inst_req.
